// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream traffic generator.
//
// Emits packets made of one header beat followed by counter-pattern payload
// beats. Packet length is fixed, swept or pseudo-random, with a partial tkeep
// on the last beat. Flow IDs rotate round-robin, tvalid is throttled by an
// LFSR duty gate, and a packet-count limit plus throughput counters are kept.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | out of reset, waiting for cfg_start
// HEAD  | offering beat 0 (header) of the current packet
// BODY  | offering payload beats 1..n-1 of the current packet
// DONE  | run finished (stop or count limit); waiting for cfg_start
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cfg_start / cfg_stop   start pulse (latches cfg_*), graceful stop pulse
//   cfg_mode               0/3 fixed, 1 sweep, 2 random length
//   cfg_len_min/max        length bounds in bytes
//   cfg_pkt_count          packets per run, 0 = unlimited
//   cfg_duty               beat offered when lfsr[7:0] <= cfg_duty
//   cfg_flow_num           number of round-robin flows (0 treated as 1)
//   m_axis_*               AXI-Stream master
//   busy, done             status
//   stat_pkt_cnt/byte_cnt  completed packets / bytes in the current run
module axis_pkt_gen #(
    parameter int          DATA_WIDTH = 512,
    parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int          LEN_WIDTH  = 16,
    parameter int          FLOW_WIDTH = 5,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic [1:0]            cfg_mode,
    input  logic [LEN_WIDTH-1:0]  cfg_len_min,
    input  logic [LEN_WIDTH-1:0]  cfg_len_max,
    input  logic [31:0]           cfg_pkt_count,
    input  logic [7:0]            cfg_duty,
    input  logic [FLOW_WIDTH-1:0] cfg_flow_num,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           stat_pkt_cnt,
    output logic [63:0]           stat_byte_cnt
);

    // Length arithmetic carries one extra bit so sweep/random sums cannot wrap.
    localparam int                LW1       = LEN_WIDTH + 1;
    localparam logic [LW1-1:0]    KEEP_L    = LW1'(KEEP_WIDTH);
    localparam logic [LW1-1:0]    LEN_MASK  = {1'b0, {LEN_WIDTH{1'b1}}};
    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
    localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    tvalid_q, tvalid_d;
    logic [LW1-1:0]          beat_q, beat_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [31:0]             seq_q, seq_d;
    logic [FLOW_WIDTH-1:0]   flow_q, flow_d;
    logic [31:0]             pkt_cnt_q, pkt_cnt_d;
    logic [63:0]             byte_cnt_q, byte_cnt_d;
    logic [31:0]             lfsr_q, lfsr_d;
    logic                    stop_q, stop_d;
    logic [1:0]              mode_q, mode_d;
    logic [LEN_WIDTH-1:0]    len_min_q, len_min_d;
    logic [LEN_WIDTH-1:0]    len_max_q, len_max_d;
    logic [31:0]             pkt_count_q, pkt_count_d;
    logic [7:0]              duty_q, duty_d;
    logic [FLOW_WIDTH-1:0]   flow_num_q, flow_num_d;

    logic [LW1-1:0]          nbeats;
    logic [LW1-1:0]          rem;
    logic                    last_beat;
    logic                    gate;
    logic                    hs;
    logic                    run_end;
    logic [FLOW_WIDTH-1:0]   flow_eff;
    logic [FLOW_WIDTH:0]     flow_inc;
    logic [FLOW_WIDTH-1:0]   flow_nxt;
    logic [DATA_WIDTH-1:0]   beat_data;
    logic [KEEP_WIDTH-1:0]   beat_keep;

    // Length of the next packet. 'first' selects the sweep start point.
    function automatic logic [LEN_WIDTH-1:0] pick_len(
        input logic [1:0]           mode,
        input logic [LEN_WIDTH-1:0] mn_raw,
        input logic [LEN_WIDTH-1:0] mx_raw,
        input logic [LEN_WIDTH-1:0] prev,
        input logic                 first,
        input logic [15:0]          rnd
    );
        logic [LW1-1:0] mn;
        logic [LW1-1:0] mx;
        logic [LW1-1:0] nxt;
        mn = ({1'b0, mn_raw} < KEEP_L) ? KEEP_L : {1'b0, mn_raw};
        mx = ({1'b0, mx_raw} < mn) ? mn : {1'b0, mx_raw};
        case (mode)
            2'd1: begin
                nxt = first ? mn : ({1'b0, prev} + KEEP_L);
                if (nxt > mx) nxt = mn;
            end
            2'd2: begin
                nxt = mn + (LW1'(rnd) & LEN_MASK);
                if (nxt > mx) nxt = mx;
            end
            default: nxt = mn;
        endcase
        return nxt[LEN_WIDTH-1:0];
    endfunction

    assign nbeats    = ({1'b0, len_q} + KEEP_L - LW1'(1)) / KEEP_L;
    assign rem       = {1'b0, len_q} % KEEP_L;
    assign last_beat = (beat_q == nbeats - LW1'(1));
    assign gate      = (lfsr_q[7:0] <= duty_q);
    assign hs        = tvalid_q && m_axis_tready;
    assign run_end   = stop_q || cfg_stop ||
                       ((pkt_count_q != 32'd0) && (pkt_cnt_q + 32'd1 == pkt_count_q));

    assign flow_eff  = (flow_num_q == '0) ? FLOW_WIDTH'(1) : flow_num_q;
    assign flow_inc  = {1'b0, flow_q} + (FLOW_WIDTH+1)'(1);
    assign flow_nxt  = (flow_inc >= {1'b0, flow_eff}) ? '0 : flow_inc[FLOW_WIDTH-1:0];

    // Beat contents derive only from registered state, so they hold while
    // a beat waits for tready.
    always_comb begin
        beat_data = '0;
        if (beat_q == '0) begin
            beat_data[15:0]              = 16'(len_q);
            beat_data[16 +: FLOW_WIDTH]  = flow_q;
            beat_data[63:32]             = seq_q;
        end else begin
            beat_data[31:0] = seq_q + 32'(beat_q);
        end
    end

    always_comb begin
        beat_keep = '1;
        if (last_beat && (rem != '0)) begin
            for (int i = 0; i < KEEP_WIDTH; i++) begin
                beat_keep[i] = (i < int'(rem));
            end
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tvalid_q ? beat_data : '0;
    assign m_axis_tkeep  = tvalid_q ? beat_keep : '0;
    assign m_axis_tlast  = tvalid_q && last_beat;
    assign busy          = (state_q == S_HEAD) || (state_q == S_BODY);
    assign done          = (state_q == S_DONE);
    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_byte_cnt = byte_cnt_q;

    always_comb begin
        state_d     = state_q;
        tvalid_d    = tvalid_q;
        beat_d      = beat_q;
        len_d       = len_q;
        seq_d       = seq_q;
        flow_d      = flow_q;
        pkt_cnt_d   = pkt_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        stop_d      = stop_q;
        mode_d      = mode_q;
        len_min_d   = len_min_q;
        len_max_d   = len_max_q;
        pkt_count_d = pkt_count_q;
        duty_d      = duty_q;
        flow_num_d  = flow_num_q;
        lfsr_d      = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

        case (state_q)
            S_IDLE, S_DONE: begin
                tvalid_d = 1'b0;
                if (cfg_start) begin
                    mode_d      = cfg_mode;
                    len_min_d   = cfg_len_min;
                    len_max_d   = cfg_len_max;
                    pkt_count_d = cfg_pkt_count;
                    duty_d      = cfg_duty;
                    flow_num_d  = cfg_flow_num;
                    seq_d       = '0;
                    flow_d      = '0;
                    pkt_cnt_d   = '0;
                    byte_cnt_d  = '0;
                    stop_d      = 1'b0;
                    beat_d      = '0;
                    len_d       = pick_len(cfg_mode, cfg_len_min, cfg_len_max,
                                           len_q, 1'b1, lfsr_q[31:16]);
                    state_d     = S_HEAD;
                end
            end
            S_HEAD, S_BODY: begin
                if (cfg_stop) stop_d = 1'b1;
                if (!tvalid_q) begin
                    tvalid_d = gate;
                end else if (hs) begin
                    if (last_beat) begin
                        seq_d      = seq_q + 32'd1;
                        flow_d     = flow_nxt;
                        pkt_cnt_d  = pkt_cnt_q + 32'd1;
                        byte_cnt_d = byte_cnt_q + 64'(len_q);
                        if (run_end) begin
                            tvalid_d = 1'b0;
                            state_d  = S_DONE;
                        end else begin
                            beat_d   = '0;
                            len_d    = pick_len(mode_q, len_min_q, len_max_q,
                                                len_q, 1'b0, lfsr_q[31:16]);
                            tvalid_d = gate;
                            state_d  = S_HEAD;
                        end
                    end else begin
                        beat_d   = beat_q + LW1'(1);
                        tvalid_d = gate;
                        state_d  = S_BODY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tvalid_q    <= 1'b0;
            beat_q      <= '0;
            len_q       <= '0;
            seq_q       <= '0;
            flow_q      <= '0;
            pkt_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            lfsr_q      <= LFSR_SEED;
            stop_q      <= 1'b0;
            mode_q      <= '0;
            len_min_q   <= '0;
            len_max_q   <= '0;
            pkt_count_q <= '0;
            duty_q      <= '0;
            flow_num_q  <= '0;
        end else begin
            state_q     <= state_d;
            tvalid_q    <= tvalid_d;
            beat_q      <= beat_d;
            len_q       <= len_d;
            seq_q       <= seq_d;
            flow_q      <= flow_d;
            pkt_cnt_q   <= pkt_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            lfsr_q      <= lfsr_d;
            stop_q      <= stop_d;
            mode_q      <= mode_d;
            len_min_q   <= len_min_d;
            len_max_q   <= len_max_d;
            pkt_count_q <= pkt_count_d;
            duty_q      <= duty_d;
            flow_num_q  <= flow_num_d;
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: self-checking bench for axis_pkt_gen (default parameters).
// A packet-level reference model runs alongside the DUT and is compared on
// every cycle; directed scenarios add literal expectations on top.
module tb_axis_pkt_gen;

    localparam int          DW   = 512;
    localparam int          KW   = DW / 8;
    localparam int          LW   = 16;
    localparam int          FW   = 5;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_start, cfg_stop;
    logic [1:0]     cfg_mode;
    logic [LW-1:0]  cfg_len_min, cfg_len_max;
    logic [31:0]    cfg_pkt_count;
    logic [7:0]     cfg_duty;
    logic [FW-1:0]  cfg_flow_num;
    logic [DW-1:0]  tdata;
    logic [KW-1:0]  tkeep;
    logic           tvalid, tready, tlast;
    logic           busy, done;
    logic [31:0]    stat_pkt_cnt;
    logic [63:0]    stat_byte_cnt;

    always #5 clk = ~clk;

    axis_pkt_gen #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW), .FLOW_WIDTH(FW), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_mode(cfg_mode),
        .cfg_len_min(cfg_len_min), .cfg_len_max(cfg_len_max),
        .cfg_pkt_count(cfg_pkt_count), .cfg_duty(cfg_duty), .cfg_flow_num(cfg_flow_num),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast),
        .busy(busy), .done(done),
        .stat_pkt_cnt(stat_pkt_cnt), .stat_byte_cnt(stat_byte_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_active, m_done, m_valid, m_stop;
    int          m_len, m_beat, m_flow;
    logic [31:0] m_seq, m_pkt, m_lfsr;
    logic [63:0] m_bytes;
    int          m_mode, m_min, m_max, m_duty, m_fnum;
    logic [31:0] m_count;

    function automatic int beats_of(input int len);
        return (len + KW - 1) / KW;
    endfunction

    // One step of the Galois LFSR for x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    function automatic int pick_len(input int mode, input int mn_raw, input int mx_raw,
                                    input int prev, input bit first, input int rnd);
        int mn, mx, n;
        mn = (mn_raw < KW) ? KW : mn_raw;
        mx = (mx_raw < mn) ? mn : mx_raw;
        if (mode == 1) begin
            n = first ? mn : prev + KW;
            if (n > mx) n = mn;
        end else if (mode == 2) begin
            n = mn + rnd;
            if (n > mx) n = mx;
        end else begin
            n = mn;
        end
        return n;
    endfunction

    function automatic logic [DW-1:0] exp_data(input int len, input int flow,
                                               input logic [31:0] seq, input int k);
        logic [DW-1:0] d;
        logic [15:0]   l16;
        logic [FW-1:0] f;
        d   = '0;
        l16 = 16'(len);
        f   = FW'(flow);
        if (k == 0) begin
            d[15:0]      = l16;
            d[16 +: FW]  = f;
            d[63:32]     = seq;
        end else begin
            d[31:0] = seq + 32'(k);
        end
        return d;
    endfunction

    function automatic logic [KW-1:0] exp_keep(input int len, input int k);
        int r;
        r = len % KW;
        if (k == beats_of(len) - 1 && r != 0) return (64'd1 << r) - 64'd1;
        return '1;
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] l0;
        bit          g;
        l0 = m_lfsr;
        g  = (int'(l0[7:0]) <= m_duty);
        if (rst) begin
            m_active = 0; m_done = 0; m_valid = 0; m_stop = 0;
            m_len = 0; m_beat = 0; m_flow = 0; m_seq = 0; m_pkt = 0; m_bytes = 0;
            m_lfsr = SEED;
        end else begin
            if (!m_active) begin
                if (cfg_start) begin
                    m_mode = cfg_mode; m_min = cfg_len_min; m_max = cfg_len_max;
                    m_count = cfg_pkt_count; m_duty = cfg_duty; m_fnum = cfg_flow_num;
                    m_seq = 0; m_flow = 0; m_pkt = 0; m_bytes = 0; m_stop = 0;
                    m_len = pick_len(m_mode, m_min, m_max, 0, 1'b1, int'(l0[31:16]));
                    m_beat = 0; m_valid = 0; m_active = 1; m_done = 0;
                end
            end else begin
                if (cfg_stop) m_stop = 1;
                if (!m_valid) begin
                    m_valid = g;
                end else if (tready) begin
                    if (m_beat == beats_of(m_len) - 1) begin
                        m_seq   = m_seq + 1;
                        m_flow  = (m_flow + 1) % ((m_fnum == 0) ? 1 : m_fnum);
                        m_pkt   = m_pkt + 1;
                        m_bytes = m_bytes + 64'(m_len);
                        if (m_stop || (m_count != 0 && m_pkt == m_count)) begin
                            m_active = 0; m_done = 1; m_valid = 0;
                        end else begin
                            m_len   = pick_len(m_mode, m_min, m_max, m_len, 1'b0, int'(l0[31:16]));
                            m_beat  = 0;
                            m_valid = g;
                        end
                    end else begin
                        m_beat  = m_beat + 1;
                        m_valid = g;
                    end
                end
            end
            m_lfsr = lfsr_step(l0);
        end
    end

    always @(negedge clk) begin : compare
        check("tvalid", 64'(tvalid), 64'(m_valid));
        check("busy", 64'(busy), 64'(m_active));
        check("done", 64'(done), 64'(m_done));
        check("stat_pkt_cnt", 64'(stat_pkt_cnt), 64'(m_pkt));
        check("stat_byte_cnt", stat_byte_cnt, m_bytes);
        check("tlast", 64'(tlast), 64'(m_valid && (m_beat == beats_of(m_len) - 1)));
        if (m_valid) begin
            check_wide("tdata", tdata, exp_data(m_len, m_flow, m_seq, m_beat));
            check("tkeep", tkeep, exp_keep(m_len, m_beat));
        end
    end

    // ---------------- packet log for literal checks ----------------
    int          h_len[$], h_flow[$], h_seq[$], p_beats[$], p_data[$];
    logic [63:0] p_keep[$];
    int          mon_beat = 0;
    int          busy_cyc = 0, valid_cyc = 0;

    always @(negedge clk) begin : monitor
        if (rst) begin
            mon_beat = 0;
        end else begin
            if (busy) begin
                busy_cyc++;
                if (tvalid) valid_cyc++;
            end
            if (tvalid && tready) begin
                if (mon_beat == 0) begin
                    h_len.push_back(int'(tdata[15:0]));
                    h_flow.push_back(int'(tdata[16 +: FW]));
                    h_seq.push_back(int'(tdata[63:32]));
                end
                if (tlast) begin
                    p_beats.push_back(mon_beat + 1);
                    p_keep.push_back(tkeep);
                    p_data.push_back(int'(tdata[31:0]));
                    mon_beat = 0;
                end else begin
                    mon_beat++;
                end
            end
        end
    end

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_run(input int mode, input int mn, input int mx, input int cnt,
                             input int duty, input int fnum);
        cfg_mode = 2'(mode); cfg_len_min = LW'(mn); cfg_len_max = LW'(mx);
        cfg_pkt_count = 32'(cnt); cfg_duty = 8'(duty); cfg_flow_num = FW'(fnum);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        // Scramble the inputs afterwards: the run must use the latched copy.
        cfg_mode = 2'($urandom); cfg_len_min = LW'($urandom); cfg_len_max = LW'($urandom);
        cfg_pkt_count = $urandom; cfg_duty = 8'($urandom); cfg_flow_num = FW'($urandom);
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check(name, 64'(done), 64'd1);
    endtask

    task automatic wait_beat(input string name, input int beat, input int budget);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            if (tvalid && mon_beat == beat) hit = 1;
            else tick();
        end
        check(name, 64'(hit), 64'd1);
    endtask

    initial begin
        int b;
        rst = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; tready = 1'b1;
        cfg_mode = '0; cfg_len_min = '0; cfg_len_max = '0; cfg_pkt_count = '0;
        cfg_duty = '0; cfg_flow_num = '0;
        repeat (3) tick();
        check("reset tvalid", 64'(tvalid), 64'd0);
        check("reset busy/done", {62'd0, busy, done}, 64'd0);
        check("reset stats", stat_byte_cnt | 64'(stat_pkt_cnt), 64'd0);
        check_wide("reset tdata", tdata, '0);
        check("reset tkeep", tkeep, 64'd0);
        rst = 1'b0;
        tick();

        // fixed 3-packet run
        b = h_len.size();
        start_run(0, 64, 0, 3, 255, 1);
        wait_done("t1 done", 200);
        check("t1 pkt_cnt", 64'(stat_pkt_cnt), 64'd3);
        check("t1 byte_cnt", stat_byte_cnt, 64'd192);
        for (int i = 0; i < 3; i++) begin
            check("t1 hdr len", 64'(at(h_len, b + i)), 64'h40);
            check("t1 hdr seq", 64'(at(h_seq, b + i)), 64'(i));
            check("t1 beats", 64'(at(p_beats, b + i)), 64'd1);
        end
        check("t1 keep", (p_keep.size() > b) ? p_keep[b] : 64'd0, {64{1'b1}});

        // partial last beat
        b = p_beats.size();
        start_run(0, 100, 0, 1, 255, 1);
        wait_done("t2 done", 200);
        check("t2 beats", 64'(at(p_beats, b)), 64'd2);
        check("t2 last data", 64'(at(p_data, b)), 64'd1);
        check("t2 last keep", (p_keep.size() > b) ? p_keep[b] : 64'd0, 64'hF_FFFF_FFFF);
        check("t2 byte_cnt", stat_byte_cnt, 64'd100);

        // sweep wrap
        b = p_beats.size();
        start_run(1, 64, 192, 4, 255, 1);
        wait_done("t3 done", 300);
        check("t3 len0", 64'(at(h_len, b)), 64'd64);
        check("t3 len1", 64'(at(h_len, b + 1)), 64'd128);
        check("t3 len2", 64'(at(h_len, b + 2)), 64'd192);
        check("t3 len3", 64'(at(h_len, b + 3)), 64'd64);
        check("t3 beats1", 64'(at(p_beats, b + 1)), 64'd2);
        check("t3 beats2", 64'(at(p_beats, b + 2)), 64'd3);

        // backpressure and flows
        b = h_flow.size();
        start_run(0, 256, 0, 4, 255, 3);
        wait_beat("t4 reach beat1", 1, 100);
        tready = 1'b0;
        repeat (5) tick();
        tready = 1'b1;
        wait_done("t4 done", 300);
        check("t4 flow0", 64'(at(h_flow, b)), 64'd0);
        check("t4 flow1", 64'(at(h_flow, b + 1)), 64'd1);
        check("t4 flow2", 64'(at(h_flow, b + 2)), 64'd2);
        check("t4 flow3", 64'(at(h_flow, b + 3)), 64'd0);

        // throttle: roughly half of the busy cycles carry a valid beat
        start_run(0, 4096, 0, 0, 127, 1);
        busy_cyc = 0; valid_cyc = 0;
        repeat (16000) tick();
        check("t5 duty low", 64'(valid_cyc * 100 >= busy_cyc * 47), 64'd1);
        check("t5 duty high", 64'(valid_cyc * 100 <= busy_cyc * 53), 64'd1);
        cfg_stop = 1'b1; tick(); cfg_stop = 1'b0;
        wait_done("t5 done", 2000);

        // stop on beat 1 of a 4-beat packet
        b = p_beats.size();
        start_run(0, 256, 0, 0, 255, 1);
        wait_beat("t6 reach beat1", 1, 100);
        cfg_stop = 1'b1; tick(); cfg_stop = 1'b0;
        wait_done("t6 done", 100);
        check("t6 last pkt beats", 64'(at(p_beats, p_beats.size() - 1)), 64'd4);
        check("t6 one pkt", 64'(stat_pkt_cnt), 64'd1);
        valid_cyc = 0;
        repeat (20) begin
            if (tvalid) valid_cyc++;
            tick();
        end
        check("t6 quiet after done", 64'(valid_cyc), 64'd0);

        // reset mid-packet
        start_run(0, 256, 0, 0, 255, 1);
        wait_beat("t7 reach beat2", 2, 100);
        rst = 1'b1;
        tick();
        check("t7 tvalid", 64'(tvalid), 64'd0);
        check("t7 tlast", 64'(tlast), 64'd0);
        check("t7 stats", stat_byte_cnt | 64'(stat_pkt_cnt), 64'd0);
        check("t7 idle", {62'd0, busy, done}, 64'd0);
        rst = 1'b0;
        tick();
        b = h_seq.size();
        start_run(0, 256, 0, 2, 255, 1);
        wait_done("t7 done", 100);
        check("t7 seq restart", 64'(at(h_seq, b)), 64'd0);

        // randomized runs against the model
        for (int r = 0; r < 12; r++) begin
            start_run($urandom_range(0, 3), $urandom_range(0, 300), $urandom_range(0, 400),
                      $urandom_range(1, 6), $urandom_range(32, 255), $urandom_range(0, 7));
            for (int i = 0; i < 4000 && !done; i++) begin
                tready    = ($urandom_range(0, 3) != 0);
                cfg_stop  = ($urandom_range(0, 299) == 0);
                cfg_start = busy && ($urandom_range(0, 99) == 0);
                tick();
            end
            cfg_stop = 1'b0; cfg_start = 1'b0; tready = 1'b1;
            check("rand done", 64'(done), 64'd1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
